onehot_codec: RTL and testbench

ONEHOT_CODEC -- requirements
Module: onehot_codec

---
 rtl/onehot_codec.sv | 122 ++++++++++++
 tb/tb_onehot_codec.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/onehot_codec.sv
// onehot_codec -- binary <-> one-hot converter with a registered
// valid/ready output stage and a saturating error counter.
//
// mode = 0 decodes in_data[ENC_W-1:0] into a one-hot vector.
// mode = 1 encodes a one-hot vector into its binary index.
// An all-zero encode input is always flagged with out_err.
//
// Optional build macro: ONEHOT_CODEC_PRIO_EN
//   defined   : encode of a multi-hot vector returns the lowest set bit index, no error
//   undefined : encode of a multi-hot vector returns 0 with out_err set
//
// Reset is synchronous and active-low; every state element updates on the rising clk edge.
module onehot_codec #(
    parameter  int ENC_W = 3,
    parameter  int CNT_W = 8,
    localparam int OH_W  = 2 ** ENC_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode,
    input  logic [OH_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OH_W-1:0]  out_data,
    output logic             out_err,
    input  logic             err_clr,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic             MODE_DEC = 1'b0;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic             in_fire;
    logic             out_fire;
    logic [OH_W-1:0]  dec_data;
    logic [ENC_W-1:0] low_idx;
    logic             enc_zero;
    logic             enc_multi;
    logic [OH_W-1:0]  nxt_data;
    logic             nxt_err;

    // The output register can take a new result whenever it is empty or
    // is being drained this very cycle, giving one result per clock.
    assign in_ready = ~out_valid | out_ready;
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // Decode: set the single bit addressed by the low ENC_W bits of in_data.
    always_comb begin
        // NOTE: every combinational output gets a default before any
        // conditional update, so no path leaves it unassigned (no latch).
        dec_data = '0;
        dec_data[in_data[ENC_W-1:0]] = 1'b1;
    end

    // Encode: index of the lowest set bit (scan from the top so the
    // lowest hit is the last assignment to stick).
    always_comb begin
        low_idx = '0;
        for (int k = OH_W - 1; k >= 0; k--) begin
            if (in_data[k]) begin
                low_idx = ENC_W'(k);
            end
        end
    end

    // Clearing the lowest set bit leaves something only if two or more bits were set.
    assign enc_zero  = ~|in_data;
    assign enc_multi = |(in_data & (in_data - OH_W'(1)));

    // Select the result that will be captured on an input transfer.
    always_comb begin
        nxt_data = '0;
        nxt_err  = 1'b0;
        if (mode == MODE_DEC) begin
            nxt_data = dec_data;
        end else if (enc_zero) begin
            nxt_err  = 1'b1;
        end else if (enc_multi) begin
`ifdef ONEHOT_CODEC_PRIO_EN
            nxt_data = OH_W'(low_idx);
`else
            nxt_err  = 1'b1;
`endif
        end else begin
            nxt_data = OH_W'(low_idx);
        end
    end

    // Output register: load on input transfer, empty on a bare output
    // transfer, otherwise hold (data is kept even after out_valid drops).
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of block order.
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_err   <= 1'b0;
        end else if (in_fire) begin
            out_valid <= 1'b1;
            out_data  <= nxt_data;
            out_err   <= nxt_err;
        end else if (out_fire) begin
            out_valid <= 1'b0;
        end
    end

    // Error counter: counts flagged results taken downstream, saturates,
    // and a clear request wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (err_clr) begin
            err_cnt <= '0;
        end else if (out_fire && out_err && (err_cnt != CNT_MAX)) begin
            err_cnt <= err_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_onehot_codec.sv
// tb_onehot_codec -- scoreboard bench for onehot_codec.
// Inputs change 1 ns after the rising edge; the scoreboard samples
// handshakes on the falling edge. Expectations follow the build macro
// ONEHOT_CODEC_PRIO_EN exactly like the design does.
module tb_onehot_codec;

    localparam int ENC_W = 3;
    localparam int OH_W  = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, mode, out_ready, err_clr;
    logic [7:0] in_data;
    logic       in_ready, out_valid, out_err;
    logic [7:0] out_data;
    logic [7:0] err_cnt;

    logic       in_valid2, mode2, out_ready2, err_clr2;
    logic [7:0] in_data2;
    logic       in_ready2, out_valid2, out_err2;
    logic [7:0] out_data2;
    logic [1:0] err_cnt2;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [8:0] sb[$];
    int         exp_cnt  = 0;

    onehot_codec #(.ENC_W(ENC_W), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_err(out_err), .err_clr(err_clr), .err_cnt(err_cnt)
    );

    onehot_codec #(.ENC_W(ENC_W), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .mode(mode2), .in_data(in_data2), .out_valid(out_valid2), .out_ready(out_ready2),
        .out_data(out_data2), .out_err(out_err2), .err_clr(err_clr2), .err_cnt(err_cnt2)
    );

    always #5 clk = ~clk;

    // Reference behaviour: returns {err, data}.
    function automatic logic [8:0] model(input logic m, input logic [7:0] d);
        int ones = 0;
        int low  = 0;
        if (!m) return {1'b0, 8'h01 << d[2:0]};
        for (int k = 7; k >= 0; k--) begin
            if (d[k]) begin
                ones++;
                low = k;
            end
        end
        if (ones == 0) return {1'b1, 8'h00};
        if (ones == 1) return {1'b0, 8'(low)};
`ifdef ONEHOT_CODEC_PRIO_EN
        return {1'b0, 8'(low)};
`else
        return {1'b1, 8'h00};
`endif
    endfunction

    // Scoreboard: pop and compare on output transfer, push on input transfer.
    always @(negedge clk) begin
        logic [8:0] e;
        if (rst_n === 1'b1) begin
            n_checks++;
            if (in_ready !== (!out_valid || out_ready))
                $display("FAIL in_ready_rule: got %b expected %b", in_ready, !out_valid || out_ready);
            else n_pass++;
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                n_checks++;
                if (sb.size() == 0) begin
                    $display("FAIL sb_unexpected: got data %02h err %b expected no result", out_data, out_err);
                end else begin
                    e = sb.pop_front();
                    if ({out_err, out_data} !== e)
                        $display("FAIL sb_result: got err %b data %02h expected err %b data %02h",
                                 out_err, out_data, e[8], e[7:0]);
                    else n_pass++;
                    if (e[8] && exp_cnt != 255) exp_cnt++;
                end
            end
            if (in_valid === 1'b1 && in_ready === 1'b1) sb.push_back(model(mode, in_data));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 0; mode = 0; in_data = 0; out_ready = 1; err_clr = 0;
        in_valid2 = 0; mode2 = 0; in_data2 = 0; out_ready2 = 1; err_clr2 = 0;
        tick();
        n_checks++;
        if ({out_valid, out_data, out_err, err_cnt} !== 18'h0)
            $display("FAIL reset_state: got v%b d%02h e%b c%0d expected all zero", out_valid, out_data, out_err, err_cnt);
        else n_pass++;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        else n_pass++;
        tick();
        rst_n = 1'b1;
        sb.delete();
        exp_cnt = 0;
        tick();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL post_reset: got rdy %b v %b expected rdy 1 v 0", in_ready, out_valid);
        else n_pass++;
    endtask

    task automatic test_decode();
        mode = 0;
        out_ready = 1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1;
            in_data = 8'(i) | 8'hA8;  // upper bits must be ignored
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== (8'h01 << i) || out_err !== 1'b0)
                $display("FAIL decode_%0d: got v%b d%02h e%b expected v1 d%02h e0",
                         i, out_valid, out_data, out_err, 8'h01 << i);
            else n_pass++;
        end
        in_valid = 0;
        tick();
    endtask

    task automatic test_encode();
        mode = 1; out_ready = 1; in_valid = 1; in_data = 8'h10;
        tick();
        n_checks++;
        if (out_data !== 8'd4 || out_err !== 1'b0)
            $display("FAIL encode_10: got d%02h e%b expected d04 e0", out_data, out_err);
        else n_pass++;
        in_data = 8'h00;
        tick();
        n_checks++;
        if (out_data !== 8'd0 || out_err !== 1'b1)
            $display("FAIL encode_00: got d%02h e%b expected d00 e1", out_data, out_err);
        else n_pass++;
        in_valid = 0;
        tick();
        n_checks++;
        if (err_cnt !== 8'd1 || out_valid !== 1'b0 || out_data !== 8'd0)
            $display("FAIL encode_cnt: got c%0d v%b d%02h expected c1 v0 d00", err_cnt, out_valid, out_data);
        else n_pass++;
    endtask

    task automatic test_multi();
        mode = 1; out_ready = 1; in_valid = 1; in_data = 8'h28;
        tick();
        in_valid = 0;
        n_checks++;
`ifdef ONEHOT_CODEC_PRIO_EN
        if (out_data !== 8'd3 || out_err !== 1'b0)
            $display("FAIL encode_28: got d%02h e%b expected d03 e0", out_data, out_err);
        else n_pass++;
`else
        if (out_data !== 8'd0 || out_err !== 1'b1)
            $display("FAIL encode_28: got d%02h e%b expected d00 e1", out_data, out_err);
        else n_pass++;
`endif
        tick();
        n_checks++;
        if (err_cnt !== 8'(exp_cnt)) $display("FAIL multi_cnt: got %0d expected %0d", err_cnt, exp_cnt);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        mode = 0; out_ready = 0; in_valid = 1; in_data = 8'd2;
        tick();
        in_data = 8'd5;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'h04)
                $display("FAIL stall_%0d: got rdy%b v%b d%02h expected rdy0 v1 d04", i, in_ready, out_valid, out_data);
            else n_pass++;
            if (i < 4) tick();
        end
        out_ready = 1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL release_rdy: got %b expected 1", in_ready);
        else n_pass++;
        tick();
        in_valid = 0;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h20)
            $display("FAIL release_next: got v%b d%02h expected v1 d20", out_valid, out_data);
        else n_pass++;
        tick();
        tick();
    endtask

    task automatic test_mode_mix();
        logic [7:0] d;
        for (int c = 0; c < 80; c++) begin
            in_valid  = 1'($urandom_range(0, 3) != 0);
            out_ready = 1'($urandom_range(0, 3) != 0);
            mode      = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       d = 8'h00;
                1, 2:    d = 8'h01 << $urandom_range(0, 7);
                default: d = 8'($urandom) | 8'h81;
            endcase
            in_data = mode ? d : 8'($urandom);
            tick();
        end
        in_valid = 0; out_ready = 1;
        tick(); tick();
        n_checks++;
        if (sb.size() != 0) $display("FAIL mix_drain: got %0d pending expected 0", sb.size());
        else n_pass++;
        n_checks++;
        if (err_cnt !== 8'(exp_cnt)) $display("FAIL mix_cnt: got %0d expected %0d", err_cnt, exp_cnt);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        mode = 1; in_data = 8'h00; in_valid = 1; out_ready = 0;
        tick();
        in_valid = 0;
        rst_n = 0;
        sb.delete();
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 8'd0 || out_err !== 1'b0 || err_cnt !== 8'd0 || in_ready !== 1'b1)
            $display("FAIL reset_mid: got v%b d%02h e%b c%0d rdy%b expected v0 d00 e0 c0 rdy1",
                     out_valid, out_data, out_err, err_cnt, in_ready);
        else n_pass++;
        rst_n = 1;
        exp_cnt = 0;
        out_ready = 1;
        tick();
    endtask

    task automatic test_saturate();
        logic [1:0] exp2;
        mode2 = 1; in_data2 = 8'h00; out_ready2 = 1; in_valid2 = 1;
        tick();
        for (int j = 1; j <= 6; j++) begin
            if (j == 6) in_valid2 = 0;
            tick();
            exp2 = (j > 3) ? 2'd3 : 2'(j);
            n_checks++;
            if (err_cnt2 !== exp2) $display("FAIL sat_%0d: got %0d expected %0d", j, err_cnt2, exp2);
            else n_pass++;
        end
        in_valid2 = 1;
        tick();
        in_valid2 = 0;
        err_clr2 = 1;
        n_checks++;
        if (out_valid2 !== 1'b1 || out_err2 !== 1'b1)
            $display("FAIL clr_setup: got v%b e%b expected v1 e1", out_valid2, out_err2);
        else n_pass++;
        tick();
        err_clr2 = 0;
        n_checks++;
        if (err_cnt2 !== 2'd0 || out_valid2 !== 1'b0)
            $display("FAIL clr_priority: got c%0d v%b expected c0 v0", err_cnt2, out_valid2);
        else n_pass++;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_decode();
        test_encode();
        test_multi();
        test_backpressure();
        test_mode_mix();
        test_reset_mid();
        test_saturate();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
